// File: rtl/register_file_mp.sv
// Multi-port register file: two write ports (ALU, MDR), NUM_RD combinational read ports
// with same-cycle write bypass, and a pending-load scoreboard for decode stalls.
module register_file_mp #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int NUM_RD   = 4,
    parameter int ZERO_REG = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_ready,
    input  logic                       alu_we,
    input  logic [ADDR_W-1:0]          alu_waddr,
    input  logic [DATA_W-1:0]          alu_wdata,
    input  logic                       mem_we,
    input  logic [ADDR_W-1:0]          mem_waddr,
    input  logic [DATA_W-1:0]          mem_wdata,
    input  logic                       ld_issue,
    input  logic [ADDR_W-1:0]          ld_addr,
    output logic [(2**ADDR_W)-1:0]     busy,
    output logic                       wr_conflict
);
    localparam int NUM_REGS = 2**ADDR_W;
    localparam bit ZR = (ZERO_REG != 0);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_next;
    logic                conflict_q;
    logic                alu_ok;
    logic                mem_ok;
    logic                ld_ok;

    // Register 0 is hard-wired when ZR, so its writes and load issues are dropped here.
    assign alu_ok = alu_we   && !(ZR && (alu_waddr == '0));
    assign mem_ok = mem_we   && !(ZR && (mem_waddr == '0));
    assign ld_ok  = ld_issue && !(ZR && (ld_addr   == '0));

    // Set is applied after clear so a same-cycle issue keeps the register busy.
    always_comb begin
        busy_next = busy_q;
        if (mem_ok) busy_next[mem_waddr] = 1'b0;
        if (ld_ok)  busy_next[ld_addr]   = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
            busy_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            if (alu_ok) regs[alu_waddr] <= alu_wdata;
            // MDR write is last so it wins an address collision.
            if (mem_ok) regs[mem_waddr] <= mem_wdata;
            busy_q     <= busy_next;
            conflict_q <= alu_ok && mem_ok && (alu_waddr == mem_waddr);
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              zero_hit;
        logic              mem_hit;
        logic              alu_hit;
        logic [DATA_W-1:0] d;

        assign a        = rd_addr[i*ADDR_W +: ADDR_W];
        assign zero_hit = ZR && (a == '0);
        assign mem_hit  = mem_we && (mem_waddr == a);
        assign alu_hit  = alu_we && (alu_waddr == a);

        always_comb begin
            d = regs[a];
            if (zero_hit)     d = '0;
            else if (mem_hit) d = mem_wdata;
            else if (alu_hit) d = alu_wdata;
        end

        assign rd_data[i*DATA_W +: DATA_W] = d;
        // Data arriving from the MDR port this cycle satisfies a pending load.
        assign rd_ready[i] = !busy_q[a] || mem_hit || zero_hit;
    end

    assign busy        = busy_q;
    assign wr_conflict = conflict_q;
endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: one default build and one ZERO_REG build share stimulus.
module tb_register_file_mp;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR*AW-1:0] rd_addr;
    logic          alu_we, mem_we, ld_issue;
    logic [AW-1:0] alu_waddr, mem_waddr, ld_addr;
    logic [DW-1:0] alu_wdata, mem_wdata;

    logic [NR*DW-1:0] rd_data, rd_data_z;
    logic [NR-1:0]    rd_ready, rd_ready_z;
    logic [15:0]      busy, busy_z;
    logic             wr_conflict, wr_conflict_z;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    register_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(0)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
        .alu_we(alu_we), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .ld_issue(ld_issue), .ld_addr(ld_addr), .busy(busy), .wr_conflict(wr_conflict)
    );

    register_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut_z (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_z), .rd_ready(rd_ready_z),
        .alu_we(alu_we), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .ld_issue(ld_issue), .ld_addr(ld_addr), .busy(busy_z), .wr_conflict(wr_conflict_z)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_we = 1'b0; mem_we = 1'b0; ld_issue = 1'b0;
        alu_waddr = '0; mem_waddr = '0; ld_addr = '0;
        alu_wdata = '0; mem_wdata = '0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic [AW-1:0] a2, input logic [AW-1:0] a3);
        rd_addr = {a3, a2, a1, a0};
    endtask

    initial begin
        idle();
        rst = 1'b0;
        set_rd(0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("reset_busy", busy, 16'h0000);
        chk("reset_conflict", wr_conflict, 1'b0);
        chk("reset_busy_z", busy_z, 16'h0000);

        for (int a = 0; a < 16; a++) begin
            set_rd(a[AW-1:0], a[AW-1:0], a[AW-1:0], a[AW-1:0]);
            #1;
            chk($sformatf("reset_data_r%0d", a), rd_data, 64'h0);
            chk($sformatf("reset_ready_r%0d", a), rd_ready, 4'hF);
        end

        // ALU and MDR writes to different registers, checked through the bypass.
        tick();
        set_rd(3, 5, 7, 0);
        alu_we = 1'b1; alu_waddr = 4'd3; alu_wdata = 16'h1234;
        mem_we = 1'b1; mem_waddr = 4'd5; mem_wdata = 16'hBEEF;
        #1;
        chk("bypass_alu_p0", rd_data[0*DW +: DW], 16'h1234);
        chk("bypass_mem_p1", rd_data[1*DW +: DW], 16'hBEEF);
        chk("untouched_p2", rd_data[2*DW +: DW], 16'h0000);
        tick();
        idle();
        #1;
        chk("stored_alu_p0", rd_data[0*DW +: DW], 16'h1234);
        chk("stored_mem_p1", rd_data[1*DW +: DW], 16'hBEEF);
        chk("no_conflict", wr_conflict, 1'b0);

        // Both ports write register 7.
        alu_we = 1'b1; alu_waddr = 4'd7; alu_wdata = 16'h1111;
        mem_we = 1'b1; mem_waddr = 4'd7; mem_wdata = 16'h2222;
        #1;
        chk("conflict_bypass_p2", rd_data[2*DW +: DW], 16'h2222);
        tick();
        idle();
        #1;
        chk("conflict_pulse", wr_conflict, 1'b1);
        chk("conflict_stored", rd_data[2*DW +: DW], 16'h2222);
        tick();
        chk("conflict_drop", wr_conflict, 1'b0);

        // Scoreboard: issue load to 9.
        set_rd(3, 5, 7, 9);
        ld_issue = 1'b1; ld_addr = 4'd9;
        #1;
        chk("pre_issue_ready", rd_ready, 4'hF);
        tick();
        idle();
        #1;
        chk("issue_busy", busy, 16'h0200);
        chk("issue_ready", rd_ready, 4'b0111);
        alu_we = 1'b1; alu_waddr = 4'd9; alu_wdata = 16'h7777;
        #1;
        chk("alu_on_busy_data", rd_data[3*DW +: DW], 16'h7777);
        chk("alu_on_busy_ready", rd_ready[3], 1'b0);
        tick();
        idle();
        #1;
        chk("alu_keeps_busy", busy, 16'h0200);
        mem_we = 1'b1; mem_waddr = 4'd9; mem_wdata = 16'hCAFE;
        #1;
        chk("load_fwd_ready", rd_ready[3], 1'b1);
        chk("load_fwd_data", rd_data[3*DW +: DW], 16'hCAFE);
        tick();
        idle();
        #1;
        chk("load_clear_busy", busy, 16'h0000);
        chk("load_stored", rd_data[3*DW +: DW], 16'hCAFE);
        chk("load_ready", rd_ready, 4'hF);

        // Simultaneous set and clear on 9: set wins.
        ld_issue = 1'b1; ld_addr = 4'd9;
        tick();
        ld_issue = 1'b1; ld_addr = 4'd9;
        mem_we = 1'b1; mem_waddr = 4'd9; mem_wdata = 16'hD00D;
        #1;
        chk("setclr_fwd_ready", rd_ready[3], 1'b1);
        tick();
        idle();
        #1;
        chk("setclr_busy", busy, 16'h0200);
        chk("setclr_ready", rd_ready[3], 1'b0);
        chk("setclr_data", rd_data[3*DW +: DW], 16'hD00D);
        mem_we = 1'b1; mem_waddr = 4'd9; mem_wdata = 16'h0009;
        tick();
        idle();
        #1;
        chk("second_clear", busy, 16'h0000);

        // Register 0: hard-wired in dut_z, ordinary in dut.
        set_rd(0, 3, 5, 7);
        alu_we = 1'b1; alu_waddr = 4'd0; alu_wdata = 16'hFFFF;
        mem_we = 1'b1; mem_waddr = 4'd0; mem_wdata = 16'hFFFF;
        ld_issue = 1'b1; ld_addr = 4'd0;
        #1;
        chk("z_bypass_r0", rd_data_z[0*DW +: DW], 16'h0000);
        chk("nz_bypass_r0", rd_data[0*DW +: DW], 16'hFFFF);
        tick();
        idle();
        #1;
        chk("z_r0_data", rd_data_z[0*DW +: DW], 16'h0000);
        chk("z_busy", busy_z, 16'h0000);
        chk("z_r0_ready", rd_ready_z[0], 1'b1);
        chk("z_conflict", wr_conflict_z, 1'b0);
        chk("nz_r0_data", rd_data[0*DW +: DW], 16'hFFFF);
        chk("nz_busy", busy, 16'h0001);
        chk("nz_r0_ready", rd_ready[0], 1'b0);
        chk("nz_conflict", wr_conflict, 1'b1);

        // Reset in the middle of an outstanding load and a write.
        set_rd(4, 3, 2, 0);
        ld_issue = 1'b1; ld_addr = 4'd2;
        alu_we = 1'b1; alu_waddr = 4'd4; alu_wdata = 16'hABCD;
        tick();
        idle();
        #1;
        chk("pre_rst_busy", busy, 16'h0005);
        chk("pre_rst_busy_z", busy_z, 16'h0004);
        chk("pre_rst_r4", rd_data[0*DW +: DW], 16'hABCD);
        rst = 1'b0;
        alu_we = 1'b1; alu_waddr = 4'd4; alu_wdata = 16'h5555;
        mem_we = 1'b1; mem_waddr = 4'd4; mem_wdata = 16'h6666;
        ld_issue = 1'b1; ld_addr = 4'd6;
        tick();
        rst = 1'b1;
        idle();
        #1;
        chk("rst_r4", rd_data[0*DW +: DW], 16'h0000);
        chk("rst_r3", rd_data[1*DW +: DW], 16'h0000);
        chk("rst_busy", busy, 16'h0000);
        chk("rst_conflict", wr_conflict, 1'b0);
        chk("rst_ready", rd_ready, 4'hF);
        chk("rst_busy_z", busy_z, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
